// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Shared widths and FSM state encoding for the IF/LS memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam int c_ADDR_W = 16;
  localparam int c_DATA_W = 16;

  typedef logic [c_ADDR_W-1:0] addr_t;
  typedef logic [c_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Fetch, load/store and memory-side signals of the arbiter, named from its view.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  i_flush;
  logic  i_if_rd_enable;
  addr_t i_if_rd_addr;
  logic  o_if_rd_ready;
  data_t o_if_rd_data;
  logic  i_ls_enable;
  logic  i_ls_we;
  addr_t i_ls_addr;
  data_t i_ls_wdata;
  logic  o_ls_ready;
  data_t o_ls_rd_data;
  logic  o_mem_req;
  logic  o_mem_we;
  addr_t o_mem_addr;
  data_t o_mem_wdata;
  logic  i_mem_ack;
  data_t i_mem_rdata;

  // master: the arbiter itself; slave: fetch, LSU and memory around it
  modport master (
    input  i_flush, i_if_rd_enable, i_if_rd_addr,
    input  i_ls_enable, i_ls_we, i_ls_addr, i_ls_wdata,
    input  i_mem_ack, i_mem_rdata,
    output o_if_rd_ready, o_if_rd_data, o_ls_ready, o_ls_rd_data,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport slave (
    output i_flush, i_if_rd_enable, i_if_rd_addr,
    output i_ls_enable, i_ls_we, i_ls_addr, i_ls_wdata,
    output i_mem_ack, i_mem_rdata,
    input  o_if_rd_ready, o_if_rd_data, o_ls_ready, o_ls_rd_data,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Shares one single-ported memory between IF and LS; LS priority, IF starvation bound.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  wire           clk,
  input  wire           rst_n,
  mem_arbiter_if.master bus
);

  localparam int               CNT_W        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state,      w_state_nxt;
  logic             r_mem_req,    w_mem_req_nxt;
  logic             r_mem_we,     w_mem_we_nxt;
  addr_t            r_mem_addr,   w_mem_addr_nxt;
  data_t            r_mem_wdata,  w_mem_wdata_nxt;
  logic             r_if_ready,   w_if_ready_nxt;
  data_t            r_if_data,    w_if_data_nxt;
  logic             r_ls_ready,   w_ls_ready_nxt;
  data_t            r_ls_data,    w_ls_data_nxt;
  logic [CNT_W-1:0] r_starve_cnt, w_starve_cnt_nxt;
  logic             r_drop,       w_drop_nxt;

  logic w_if_elig;
  logic w_ls_elig;
  logic w_if_forced;

  // A port in its ready cycle is still holding its old request; it must not re-win.
  assign w_if_elig   = bus.i_if_rd_enable & ~r_if_ready & ~bus.i_flush;
  assign w_ls_elig   = bus.i_ls_enable & ~r_ls_ready;
  assign w_if_forced = w_if_elig & (r_starve_cnt == c_STARVE_MAX);

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_if_ready_nxt   = 1'b0;
    w_if_data_nxt    = r_if_data;
    w_ls_ready_nxt   = 1'b0;
    w_ls_data_nxt    = r_ls_data;
    w_starve_cnt_nxt = r_starve_cnt;
    w_drop_nxt       = r_drop;

    unique case (r_state)
      ARB_IDLE: begin
        w_drop_nxt = 1'b0;
        if (w_ls_elig && !w_if_forced) begin
          w_state_nxt     = ARB_BUSY_D;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = bus.i_ls_we;
          w_mem_addr_nxt  = bus.i_ls_addr;
          w_mem_wdata_nxt = bus.i_ls_wdata;
          if (bus.i_if_rd_enable) begin
            w_starve_cnt_nxt = (r_starve_cnt == c_STARVE_MAX) ? c_STARVE_MAX
                                                              : r_starve_cnt + 1'b1;
          end else begin
            w_starve_cnt_nxt = '0;
          end
        end else if (w_if_elig) begin
          w_state_nxt      = ARB_BUSY_I;
          w_mem_req_nxt    = 1'b1;
          w_mem_we_nxt     = 1'b0;
          w_mem_addr_nxt   = bus.i_if_rd_addr;
          w_mem_wdata_nxt  = '0;
          w_starve_cnt_nxt = '0;
        end
      end

      ARB_BUSY_I: begin
        w_drop_nxt = r_drop | bus.i_flush;
        if (bus.i_mem_ack) begin
          w_state_nxt   = ARB_IDLE;
          w_mem_req_nxt = 1'b0;
          w_drop_nxt    = 1'b0;
          // A flush on the ack cycle itself still makes the word stale.
          if (!(r_drop || bus.i_flush)) begin
            w_if_ready_nxt = 1'b1;
            w_if_data_nxt  = bus.i_mem_rdata;
          end
        end
      end

      ARB_BUSY_D: begin
        if (bus.i_mem_ack) begin
          w_state_nxt    = ARB_IDLE;
          w_mem_req_nxt  = 1'b0;
          w_ls_ready_nxt = 1'b1;
          if (!r_mem_we) begin
            w_ls_data_nxt = bus.i_mem_rdata;
          end
        end
      end

      default: begin
        w_state_nxt   = ARB_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_ready   <= 1'b0;
      r_if_data    <= '0;
      r_ls_ready   <= 1'b0;
      r_ls_data    <= '0;
      r_starve_cnt <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_if_ready   <= w_if_ready_nxt;
      r_if_data    <= w_if_data_nxt;
      r_ls_ready   <= w_ls_ready_nxt;
      r_ls_data    <= w_ls_data_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  assign bus.o_mem_req     = r_mem_req;
  assign bus.o_mem_we      = r_mem_we;
  assign bus.o_mem_addr    = r_mem_addr;
  assign bus.o_mem_wdata   = r_mem_wdata;
  assign bus.o_if_rd_ready = r_if_ready;
  assign bus.o_if_rd_data  = r_if_data;
  assign bus.o_ls_ready    = r_ls_ready;
  assign bus.o_ls_rd_data  = r_ls_data;

endmodule

`default_nettype wire
